// File: rtl/latch_writer_pkg.sv
// latch_writer_pkg: shared state encoding, counter width and default timing for latch_writer
package latch_writer_pkg;
   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;
   localparam int CNT_W = 4;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_SETUP_CYC = 2;
   localparam int DEF_PULSE_CYC = 3;
   localparam int DEF_HOLD_CYC = 2;
endpackage

// File: rtl/latch_phase_timer.sv
// latch_phase_timer: loadable down-counter timing each write phase
// ports: clk/rst (async active-high), load+load_val reload, dec steps down, zero flags count==0
module latch_phase_timer
   import latch_writer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (dec && !zero) cnt <= cnt - 1'b1;
   assign zero = (cnt == '0);
endmodule

// File: rtl/latch_writer.sv
// latch_writer: drives a latch bank through setup/enable-pulse/hold, then reads Q back and flags mismatches
// ports: CLK, R (async active-high); REQ+WDATA start a write; D/EN drive the latches;
//        Q is the latch read-back; BUSY, DONE (1-cycle), RDATA and ERR report the result
module latch_writer
   import latch_writer_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int PULSE_CYC = DEF_PULSE_CYC,
   parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
   input  logic             CLK,
   input  logic             R,
   input  logic             REQ,
   input  logic [WIDTH-1:0] WDATA,
   output logic [WIDTH-1:0] D,
   output logic             EN,
   input  logic [WIDTH-1:0] Q,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RDATA,
   output logic             ERR
);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   if (SETUP_CYC < 1 || SETUP_CYC > 15 || PULSE_CYC < 1 || PULSE_CYC > 15 ||
       HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_timing
      $error("latch_writer: SETUP_CYC/PULSE_CYC/HOLD_CYC must lie in 1..15");
   end
   state_t state, state_n;
   logic ld, dc, zero;
   logic [CNT_W-1:0] ld_val;
   always_ff @(posedge CLK or posedge R)
      if (R) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = REQ  ? SETUP : IDLE;
         SETUP:   state_n = zero ? PULSE : SETUP;
         PULSE:   state_n = zero ? HOLD  : PULSE;
         HOLD:    state_n = zero ? CHECK : HOLD;
         default: state_n = IDLE;
      endcase
   end
   // the timer reloads on each phase entry and counts down within a phase
   always_comb begin
      ld     = (state == IDLE && REQ) || ((state == SETUP || state == PULSE) && zero);
      ld_val = state == IDLE ? SETUP_LD : state == SETUP ? PULSE_LD : HOLD_LD;
      dc     = !zero && (state == SETUP || state == PULSE || state == HOLD);
      BUSY   = (state != IDLE);
   end
   latch_phase_timer u_timer (
      .clk      (CLK),
      .rst      (R),
      .load     (ld),
      .load_val (ld_val),
      .dec      (dc),
      .zero     (zero)
   );
   // D is only loaded in IDLE, so it stays put through PULSE and HOLD
   always_ff @(posedge CLK or posedge R)
      if (R) begin
         D     <= '0;
         EN    <= 1'b0;
         DONE  <= 1'b0;
         RDATA <= '0;
         ERR   <= 1'b0;
      end else begin
         DONE <= (state == CHECK);
         if (state == IDLE && REQ) D <= WDATA;
         if (state == SETUP && zero) EN <= 1'b1;
         else if (state == PULSE && zero) EN <= 1'b0;
         if (state == CHECK) begin
            RDATA <= Q;
            ERR   <= (Q != D);
         end
      end
endmodule

// File: tb/tb_latch_writer.sv
// tb_latch_writer: scoreboard bench for latch_writer driving a behavioural latch bank
module tb_latch_writer;
   typedef struct {
      logic [7:0] rd;
      logic       err;
   } exp_t;
   logic       CLK = 1'b0;
   logic       R, REQ, EN, BUSY, DONE, ERR;
   logic [7:0] WDATA, D, Q, RDATA, lat, stuck;
   exp_t       sb[$];
   int         total = 0;
   int         bad = 0;
   always #5 CLK = ~CLK;
   always_latch if (EN) lat <= D;
   assign Q = lat & ~stuck;
   latch_writer dut (
      .CLK   (CLK),
      .R     (R),
      .REQ   (REQ),
      .WDATA (WDATA),
      .D     (D),
      .EN    (EN),
      .Q     (Q),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .RDATA (RDATA),
      .ERR   (ERR)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge CLK)
      if (DONE) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexpected got=1 exp=0 at %0t", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rdata", RDATA, e.rd);
            chk("err", ERR, e.err);
         end
      end
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         chk("idle_done", DONE, 0);
         chk("idle_busy", BUSY, 0);
      end
   endtask
   // called at a falling edge; returns at the falling edge of the DONE cycle
   task automatic run(input logic [7:0] data, input logic [7:0] exp_rd, input logic exp_err,
                      input bit inj);
      REQ = 1'b1;
      WDATA = data;
      sb.push_back('{exp_rd, exp_err});
      @(posedge CLK);
      #1 REQ = 1'b0;
      WDATA = ~data;
      for (int c = 1; c <= 9; c++) begin
         @(negedge CLK);
         chk("en", EN, (c >= 3 && c <= 5));
         chk("busy", BUSY, (c <= 8));
         chk("done", DONE, (c == 9));
         chk("d", D, data);
         if (c >= 6) chk("q", Q, exp_rd);
         if (inj) begin
            REQ = (c == 4);
            if (c == 4) WDATA = 8'h3C;
         end
      end
   endtask
   initial begin
      stuck = 8'h00;
      R = 1'b1;
      REQ = 1'b1;
      WDATA = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("rst_d", D, 0);
         chk("rst_en", EN, 0);
         chk("rst_busy", BUSY, 0);
         chk("rst_done", DONE, 0);
         chk("rst_err", ERR, 0);
         chk("rst_rdata", RDATA, 0);
      end
      R = 1'b0;
      REQ = 1'b0;
      idle(2);
      run(8'hA5, 8'hA5, 1'b0, 1'b0);
      idle(2);
      run(8'h00, 8'h00, 1'b0, 1'b0);
      run(8'hFF, 8'hFF, 1'b0, 1'b0);
      idle(2);
      chk("d_held", D, 8'hFF);
      chk("q_held", Q, 8'hFF);
      stuck = 8'h01;
      run(8'h01, 8'h00, 1'b1, 1'b0);
      idle(1);
      chk("err_held", ERR, 1);
      run(8'h00, 8'h00, 1'b0, 1'b0);
      stuck = 8'h00;
      idle(2);
      run(8'h5A, 8'h5A, 1'b0, 1'b1);
      idle(3);
      REQ = 1'b1;
      WDATA = 8'h96;
      @(posedge CLK);
      #1 REQ = 1'b0;
      repeat (4) @(negedge CLK);
      chk("mid_en_before", EN, 1);
      R = 1'b1;
      #1;
      chk("mid_en", EN, 0);
      chk("mid_busy", BUSY, 0);
      chk("mid_d", D, 0);
      @(negedge CLK);
      chk("mid_done", DONE, 0);
      R = 1'b0;
      idle(3);
      run(8'hC3, 8'hC3, 1'b0, 1'b0);
      idle(3);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/latch_writer.md
Name: latch_writer

Overview:
- Synchronous initiator that writes a WIDTH-bit bank of level-sensitive D latches and reads the stored value back.
- Accepts a one-cycle request with data, then drives D and EN through a timed setup / enable-pulse / hold sequence.
- Samples the latch outputs Q after the sequence and reports the read-back value plus a mismatch flag.
- Sits between a register-mapped controller and latch storage; it is the writer/checker end of the D/EN/Q interface.

Parameters:
- WIDTH, 8, number of latch bits driven and read back.
- SETUP_CYC, 2, cycles D is stable with EN low before the enable pulse (legal range 1..15).
- PULSE_CYC, 3, cycles EN is held high (legal range 1..15).
- HOLD_CYC, 2, cycles D is held stable after EN falls (legal range 1..15).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- R  in  1  reset; asynchronous, active-high.
- REQ  in  1  write request, sampled only in IDLE.
- WDATA  in  WIDTH  data to write, captured on the accepted REQ edge.
- D  out  WIDTH  latch data inputs (registered).
- EN  out  1  latch enable (registered).
- Q  in  WIDTH  latch outputs, sampled in CHECK.
- BUSY  out  1  high while a transaction is in progress.
- DONE  out  1  one-cycle completion pulse.
- RDATA  out  WIDTH  Q value sampled in CHECK; held until the next CHECK.
- ERR  out  1  (RDATA != written data); held until the next CHECK.

Behaviour:
- Reset (R high, asynchronous): state IDLE, D=0, EN=0, BUSY=0, DONE=0, RDATA=0, ERR=0, counter=0. R asserted mid-transaction aborts it immediately: EN drops without waiting for a clock, and no DONE is issued. Operation resumes on the first CLK edge after R falls.
- States are IDLE, SETUP, PULSE, HOLD and CHECK. BUSY = (state != IDLE).
- IDLE: on an edge with REQ=1, D <= WDATA, counter <= SETUP_CYC-1, and the state moves to SETUP. REQ=0 leaves the state in IDLE with D unchanged.
- SETUP: EN=0. When the counter reaches 0, EN <= 1, counter <= PULSE_CYC-1, and the state moves to PULSE. Otherwise the counter decrements.
- PULSE: EN=1. When the counter reaches 0, EN <= 0, counter <= HOLD_CYC-1, and the state moves to HOLD.
- HOLD: EN=0 and D is unchanged. When the counter reaches 0, the state moves to CHECK.
- CHECK: lasts one cycle. RDATA <= Q, ERR <= (Q != D), DONE <= 1, and the state moves to IDLE.
- DONE is high for exactly one cycle, the first IDLE cycle after CHECK. It is cleared on the next edge.
- Latency: REQ sampled at edge 0. EN is high during cycles SETUP_CYC+1 .. SETUP_CYC+PULSE_CYC. DONE is high in cycle SETUP_CYC+PULSE_CYC+HOLD_CYC+2; with the defaults this is cycle 9.
- REQ while BUSY is ignored, with no queuing. REQ in the DONE cycle is accepted, giving back-to-back transactions.
- WDATA changes after acceptance have no effect. D holds its value indefinitely after DONE, so the latch sees a stable D with EN low.
- EN never glitches because it is a registered output. D never changes while EN=1 or during HOLD.
- Counter width is 4 bits. The counter never wraps, because each load value is at most 14.
- Parameter values outside 1..15 are illegal. They are rejected by an elaboration-time check.

Decomposition:
- Package latch_writer_pkg:
  - state enum (IDLE, SETUP, PULSE, HOLD, CHECK);
  - counter width constant (4);
  - default timing constants.
- One sub-module, latch_phase_timer:
  - loadable 4-bit down-counter;
  - inputs: load, load value, decrement;
  - output: zero flag.
- The FSM, D/EN registers and check logic stay in latch_writer.

Test Plan:
- Reset: hold R=1 with REQ=1 and WDATA=8'hFF -> D=0, EN=0, BUSY=0, DONE=0, ERR=0, RDATA=0 for all cycles.
- Write through a behavioural latch bank, WDATA=8'hA5 at edge 0, defaults:
  - EN high in cycles 3-5 only;
  - D=8'hA5 from cycle 1 onward;
  - BUSY high in cycles 1-8;
  - DONE high in cycle 9 only, with RDATA=8'hA5, ERR=0.
- Latching low then high: write 8'h00, then 8'hFF back-to-back, with REQ in the DONE cycle -> second DONE 9 cycles after the first, RDATA=8'hFF, ERR=0. Q stays 8'hFF after EN falls while D is held.
- Stuck bit: latch model with bit 0 stuck at 0, write 8'h01 -> DONE with RDATA=8'h00, ERR=1. The next write of 8'h00 clears ERR to 0.
- REQ while busy: pulse REQ with WDATA=8'h3C during PULSE of an 8'h5A write -> ignored; D stays 8'h5A and only one DONE occurs.
- Reset mid-op: assert R during PULSE -> EN=0 and BUSY=0 immediately, no DONE. A REQ after R falls completes normally.
